// File: rtl/window_3x3_gen.sv
// Raster RGB stream -> registered 3x3 neighbourhood per channel, interior windows only.
// Latency 1 cycle from the completing pixel; no backpressure, accepts one pixel per cycle.
module window_3x3_gen #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic [71:0] win_r,
  output logic [71:0] win_g,
  output logic [71:0] win_b,
  output logic        win_valid,
  output logic        win_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          emit, last_px;
  logic          win_valid_q, win_last_q;

  logic [7:0]  pix     [3];
  logic [7:0]  line1_q [3][IMG_W];
  logic [7:0]  line2_q [3][IMG_W];
  // Columns packed as {row, row-1, row-2}; s1 holds col-1, s2 holds col-2.
  logic [23:0] col_new [3];
  logic [23:0] s1_q    [3];
  logic [23:0] s2_q    [3];
  logic [71:0] win_d   [3];
  logic [71:0] win_q   [3];

  assign pix[0] = in_r;
  assign pix[1] = in_g;
  assign pix[2] = in_b;

  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    last_px = (cur_col == CW'(IMG_W - 1)) && (cur_row == RW'(IMG_H - 1));
    emit    = in_valid && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
    if (cur_col == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end else begin
      col_d = cur_col + CW'(1);
      row_d = cur_row;
    end
    for (int ch = 0; ch < 3; ch++) begin
      col_new[ch] = {pix[ch], line1_q[ch][cur_col], line2_q[ch][cur_col]};
      win_d[ch]   = {col_new[ch][23:16], s1_q[ch][23:16], s2_q[ch][23:16],
                     col_new[ch][15:8],  s1_q[ch][15:8],  s2_q[ch][15:8],
                     col_new[ch][7:0],   s1_q[ch][7:0],   s2_q[ch][7:0]};
    end
  end

  // Line storage is never cleared: the interior-only gate keeps stale rows out of windows.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int ch = 0; ch < 3; ch++) begin
        line2_q[ch][cur_col] <= line1_q[ch][cur_col];
        line1_q[ch][cur_col] <= pix[ch];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        s1_q[ch]  <= '0;
        s2_q[ch]  <= '0;
        win_q[ch] <= '0;
      end
    end else begin
      win_valid_q <= emit;
      win_last_q  <= emit && last_px;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        for (int ch = 0; ch < 3; ch++) begin
          s2_q[ch] <= s1_q[ch];
          s1_q[ch] <= col_new[ch];
        end
      end
      if (emit) begin
        for (int ch = 0; ch < 3; ch++) begin
          win_q[ch] <= win_d[ch];
        end
      end
    end
  end

  assign win_r     = win_q[0];
  assign win_g     = win_q[1];
  assign win_b     = win_q[2];
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

endmodule
